// File: rtl/tx_word_arbiter_pkg.sv
// Shared constants and types for the two-requester UART word arbiter.
// Word geometry, byte-count limit, FSM encoding and slot naming.
package tx_word_arbiter_pkg;

    localparam int WORD_SIZE_DEF  = 32;
    localparam int SIZE_WORD_DEF  = 3;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BYTES      = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        WAIT
    } state_t;

    typedef enum logic {
        SLOT0 = 1'b0,
        SLOT1 = 1'b1
    } slot_t;

    function automatic logic [1:0] slot_onehot(slot_t s);
        return (s == SLOT1) ? 2'b10 : 2'b01;
    endfunction

    function automatic slot_t slot_other(slot_t s);
        return (s == SLOT1) ? SLOT0 : SLOT1;
    endfunction

endpackage

// File: rtl/tx_word_arbiter_if.sv
// Requester offers, transmitter handshake and grant for the arbiter.
// master = requesters/UART side, slave = arbiter.
interface tx_word_arbiter_if #(
    parameter int WORD_SIZE  = tx_word_arbiter_pkg::WORD_SIZE_DEF,
    parameter int SIZE_WORD  = tx_word_arbiter_pkg::SIZE_WORD_DEF,
    parameter int DATA_WIDTH = tx_word_arbiter_pkg::DATA_WIDTH_DEF
);
    import tx_word_arbiter_pkg::*;

    logic [WORD_SIZE-1:0]  req0_data;
    logic [SIZE_WORD-1:0]  req0_size;
    logic                  req0_valid;
    logic                  req0_busy;
    logic [WORD_SIZE-1:0]  req1_data;
    logic [SIZE_WORD-1:0]  req1_size;
    logic                  req1_valid;
    logic                  req1_busy;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  tx_valid;
    logic                  tx_busy;
    logic [1:0]            grant;

    modport master (
        output req0_data, req0_size, req0_valid,
        output req1_data, req1_size, req1_valid,
        output tx_busy,
        input  req0_busy, req1_busy,
        input  tx_byte, tx_valid, grant
    );

    modport slave (
        input  req0_data, req0_size, req0_valid,
        input  req1_data, req1_size, req1_valid,
        input  tx_busy,
        output req0_busy, req1_busy,
        output tx_byte, tx_valid, grant
    );

endinterface

// File: rtl/tx_word_arbiter_slot.sv
// One holding slot: latches an offered word and byte count while empty.
// The slot stays full (busy) until the arbiter frees it.
module tx_req_slot #(
    parameter int WORD_SIZE = tx_word_arbiter_pkg::WORD_SIZE_DEF,
    parameter int SIZE_WORD = tx_word_arbiter_pkg::SIZE_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 offer,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [SIZE_WORD-1:0] size_in,
    input  logic                 free,
    output logic [WORD_SIZE-1:0] data,
    output logic [SIZE_WORD-1:0] size,
    output logic                 full,
    output logic                 busy
);
    import tx_word_arbiter_pkg::*;

    assign busy = full;

    // Capture an offer only while empty; freeing takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
            size <= '0;
        end else if (free) begin
            full <= 1'b0;
        end else if (offer && !full) begin
            full <= 1'b1;
            data <= data_in;
            size <= size_in;
        end
    end

endmodule

// File: rtl/tx_word_arbiter.sv
// Round-robin arbiter feeding two requesters' words to one UART, LSB byte
// first, one strobe per byte with a GAP cycle covering busy-rise latency.
module tx_word_arbiter #(
    parameter int WORD_SIZE  = tx_word_arbiter_pkg::WORD_SIZE_DEF,
    parameter int SIZE_WORD  = tx_word_arbiter_pkg::SIZE_WORD_DEF,
    parameter int DATA_WIDTH = tx_word_arbiter_pkg::DATA_WIDTH_DEF
) (
    input logic             clk,
    input logic             rst,
    tx_word_arbiter_if.slave bus
);
    import tx_word_arbiter_pkg::*;

    logic [WORD_SIZE-1:0]  data0, data1, data_sel;
    logic [SIZE_WORD-1:0]  size0, size1, size_sel, eff_size;
    logic                  full0, full1;
    logic                  free0, free1, do_free;
    logic [DATA_WIDTH-1:0] cur_byte;
    logic                  is_last;

    state_t     state_q, state_n;
    slot_t      owner_q, owner_n;
    slot_t      ptr_q, ptr_n;
    logic [1:0] idx_q, idx_n;
    logic       last_q, last_n;

    tx_req_slot #(.WORD_SIZE(WORD_SIZE), .SIZE_WORD(SIZE_WORD)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .offer   (bus.req0_valid),
        .data_in (bus.req0_data),
        .size_in (bus.req0_size),
        .free    (free0),
        .data    (data0),
        .size    (size0),
        .full    (full0),
        .busy    (bus.req0_busy)
    );

    tx_req_slot #(.WORD_SIZE(WORD_SIZE), .SIZE_WORD(SIZE_WORD)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .offer   (bus.req1_valid),
        .data_in (bus.req1_data),
        .size_in (bus.req1_size),
        .free    (free1),
        .data    (data1),
        .size    (size1),
        .full    (full1),
        .busy    (bus.req1_busy)
    );

    assign data_sel = (owner_q == SLOT1) ? data1 : data0;
    assign size_sel = (owner_q == SLOT1) ? size1 : size0;
    assign eff_size = (size_sel > SIZE_WORD'(MAX_BYTES)) ?
                      SIZE_WORD'(MAX_BYTES) : size_sel;
    assign is_last  = (int'(idx_q) + 1) >= int'(eff_size);
    assign free0    = do_free && (owner_q == SLOT0);
    assign free1    = do_free && (owner_q == SLOT1);

    // Pick the owned slot's byte at the current index.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (idx_q == 2'(i)) begin
                cur_byte = data_sel[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Strobe only in SEND with the transmitter ready; grant while active.
    always_comb begin
        bus.tx_valid = (state_q == SEND) && !bus.tx_busy;
        bus.tx_byte  = (state_q == SEND) ? cur_byte : '0;
        bus.grant    = (state_q == IDLE) ? 2'b00 : slot_onehot(owner_q);
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= SLOT0;
            ptr_q   <= SLOT0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            idx_q   <= idx_n;
            last_q  <= last_n;
        end
    end

    // Next state; the slot is freed on its last strobe (or in LOAD for
    // size 0), and the registered last flag decides the WAIT exit.
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        last_n  = last_q;
        do_free = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_n = '0;
                if (full0 && full1) begin
                    owner_n = ptr_q;
                    state_n = LOAD;
                end else if (full0) begin
                    owner_n = SLOT0;
                    state_n = LOAD;
                end else if (full1) begin
                    owner_n = SLOT1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                idx_n = '0;
                if (eff_size == '0) begin
                    do_free = 1'b1;
                    ptr_n   = slot_other(owner_q);
                    state_n = IDLE;
                end else if (!bus.tx_busy) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    last_n  = is_last;
                    state_n = GAP;
                    if (is_last) begin
                        do_free = 1'b1;
                        ptr_n   = slot_other(owner_q);
                    end
                end
            end
            GAP: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx_q + 2'd1;
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Directed bench for tx_word_arbiter with a 3-cycle-busy UART model.
// Bytes are logged with their cycle numbers and checked against tables.
module tb_tx_word_arbiter;
    import tx_word_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tx_word_arbiter_if bus ();

    tx_word_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         acc = 0;
    int         busy_viol = 0;
    int         fall0 = -1;
    int         fall1 = -1;
    int         base = 0;
    bit         stuck = 1'b0;
    logic [7:0] got[$];
    int         scyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART model: log strobes at negedge, raise busy for 3 cycles after.
    initial begin
        int  cnt;
        bit  start;
        logic p0, p1;
        cnt = 0;
        p0 = 1'b0;
        p1 = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (bus.tx_valid) begin
                got.push_back(bus.tx_byte);
                scyc.push_back(cyc);
                if (bus.tx_busy) busy_viol++;
                start = 1'b1;
            end
            if (p0 && !bus.req0_busy) fall0 = cyc;
            if (p1 && !bus.req1_busy) fall1 = cyc;
            p0 = bus.req0_busy;
            p1 = bus.req1_busy;
            @(posedge clk);
            #1;
            if (start) cnt = 3;
            else if (cnt > 0) cnt--;
            bus.tx_busy = (cnt > 0) || stuck;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int which, input logic [31:0] d,
                         input logic [2:0] s);
        if (which == 0) begin
            bus.req0_data = d;
            bus.req0_size = s;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_data = d;
            bus.req1_size = s;
            bus.req1_valid = 1'b1;
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic offer2(input logic [31:0] d0, input logic [31:0] d1);
        bus.req0_data = d0;
        bus.req0_size = 3'd4;
        bus.req0_valid = 1'b1;
        bus.req1_data = d1;
        bus.req1_size = 3'd4;
        bus.req1_valid = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_bytes(input string tag, input int n,
                              input bit need_idle, input int budget);
        int k;
        k = 0;
        while (!(got.size() >= n && (!need_idle || bus.grant == 2'b00))
               && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, 64'(k < budget), 64'd1);
    endtask

    task automatic chk_bytes(input string tag, input int b,
                             input logic [63:0] exp, input int n);
        logic [7:0] v;
        chk({tag, "_count"}, 64'(got.size()), 64'(b + n));
        for (int i = 0; i < n; i++) begin
            v = (b + i < got.size()) ? got[b+i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 64'(v), 64'(exp[i*8 +: 8]));
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data = '0;
        bus.req1_data = '0;
        bus.req0_size = '0;
        bus.req1_size = '0;

        // Reset values
        repeat (2) step();
        chk("rst_busy0", 64'(bus.req0_busy), 64'd0);
        chk("rst_busy1", 64'(bus.req1_busy), 64'd0);
        chk("rst_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_byte", 64'(bus.tx_byte), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        rst = 1'b1;
        step();

        // Simultaneous offers, pointer at slot 0: req0 first
        base = 0;
        offer2(32'h0D595342, 32'h0D0A2030);
        chk("both_busy0", 64'(bus.req0_busy), 64'd1);
        chk("both_busy1", 64'(bus.req1_busy), 64'd1);
        wait_bytes("both_a", base + 8, 1'b1, 200);
        chk_bytes("both_a", base, 64'h0D0A2030_0D595342, 8);

        // Single req0 word, latency, spacing and busy release
        base = 8;
        offer(0, 32'h0D0A4B4F, 3'd4);
        chk("w_busy0", 64'(bus.req0_busy), 64'd1);
        chk("w_grant_idle", 64'(bus.grant), 64'd0);
        step();
        chk("w_grant_load", 64'(bus.grant), 64'b01);
        wait_bytes("w", base + 4, 1'b1, 200);
        chk_bytes("w", base, 64'h0D0A4B4F, 4);
        chk("w_latency", 64'(scyc[base] - acc), 64'd2);
        chk("w_spacing", 64'(scyc[base+1] - scyc[base]), 64'd5);
        chk("w_busy_fall", 64'(fall0), 64'(scyc[base+3] + 1));
        chk("w_busy0_end", 64'(bus.req0_busy), 64'd0);

        // Simultaneous offers again, pointer now at slot 1: req1 first
        base = 12;
        offer2(32'h0D595342, 32'h0D0A2030);
        wait_bytes("both_b", base + 8, 1'b1, 200);
        chk_bytes("both_b", base, 64'h0D595342_0D0A2030, 8);

        // Short word, size 2
        base = 20;
        offer(1, 32'h0D0A3146, 3'd2);
        wait_bytes("s2", base + 2, 1'b1, 200);
        chk_bytes("s2", base, 64'h3146, 2);

        // Size 0: grant for one LOAD cycle, no strobe, slot released
        offer(1, 32'hAABBCCDD, 3'd0);
        chk("s0_busy1", 64'(bus.req1_busy), 64'd1);
        chk("s0_grant_idle", 64'(bus.grant), 64'd0);
        step();
        chk("s0_grant_load", 64'(bus.grant), 64'b10);
        step();
        chk("s0_grant_end", 64'(bus.grant), 64'd0);
        chk("s0_busy1_end", 64'(bus.req1_busy), 64'd0);
        repeat (5) step();
        chk("s0_no_strobe", 64'(got.size()), 64'd22);

        // Size 7 clamps to 4 bytes
        base = 22;
        offer(0, 32'h04030201, 3'd7);
        wait_bytes("s7", base + 4, 1'b1, 200);
        chk_bytes("s7", base, 64'h04030201, 4);

        // Offer into the idle slot mid-transmission; repeat offer ignored
        base = 26;
        offer(1, 32'h44434241, 3'd4);
        wait_bytes("ov_first", base + 1, 1'b0, 100);
        offer(0, 32'h0D0A4B4F, 3'd4);
        chk("ov_busy0", 64'(bus.req0_busy), 64'd1);
        offer(0, 32'hFFFFFFFF, 3'd1);
        chk("ov_busy0_hold", 64'(bus.req0_busy), 64'd1);
        wait_bytes("ov", base + 8, 1'b1, 300);
        chk_bytes("ov", base, 64'h0D0A4B4F_44434241, 8);

        // Transmitter stuck busy: FSM holds, nothing lost or repeated
        base = 34;
        offer(0, 32'h00332211, 3'd3);
        wait_bytes("stk_first", base + 1, 1'b0, 100);
        stuck = 1'b1;
        repeat (20) step();
        chk("stk_count", 64'(got.size()), 64'(base + 1));
        chk("stk_valid", 64'(bus.tx_valid), 64'd0);
        chk("stk_grant", 64'(bus.grant), 64'b01);
        stuck = 1'b0;
        wait_bytes("stk", base + 3, 1'b1, 200);
        chk_bytes("stk", base, 64'h332211, 3);
        chk("no_strobe_busy", 64'(busy_viol), 64'd0);

        // Reset mid-message aborts it
        base = 37;
        offer(0, 32'h44332211, 3'd4);
        wait_bytes("ab_two", base + 2, 1'b0, 100);
        rst = 1'b0;
        #1;
        chk("ab_grant", 64'(bus.grant), 64'd0);
        chk("ab_busy0", 64'(bus.req0_busy), 64'd0);
        chk("ab_valid", 64'(bus.tx_valid), 64'd0);
        chk("ab_byte", 64'(bus.tx_byte), 64'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (30) step();
        chk_bytes("ab", base, 64'h2211, 2);

        // Pointer back at slot 0 after reset
        base = 39;
        bus.req0_data = 32'h000000AA;
        bus.req0_size = 3'd1;
        bus.req1_data = 32'h000000BB;
        bus.req1_size = 3'd1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_bytes("ptr", base + 2, 1'b1, 200);
        chk_bytes("ptr", base, 64'hBBAA, 2);
        chk("end_busy_viol", 64'(busy_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
